// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode slice: decoder path codes,
// fetch sequencer states and the default halt word.
package mips_pkg;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC00_0000;

  typedef enum logic [3:0] {
    PATH_MFHI   = 4'b0000,
    PATH_ALU    = 4'b0001,
    PATH_LW     = 4'b0010,
    PATH_SW     = 4'b0011,
    PATH_BEQ    = 4'b0100,
    PATH_J      = 4'b0101,
    PATH_JAL    = 4'b0110,
    PATH_MULDIV = 4'b0111,
    PATH_JR     = 4'b1000
  } path_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection from the decoder path code, plus detection
// of a jr target that is not word aligned.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  path_index,
  input  logic [25:0] jump_address,
  input  logic [31:0] imm_extended,
  input  logic [31:0] rs_data,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc4;

  assign pc4 = pc + 32'd4;

  // Next-PC mux; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc  = pc4;
    misalign = 1'b0;
    case (path_index)
      PATH_J, PATH_JAL: begin
        next_pc = {pc4[31:28], jump_address, 2'b00};
      end
      PATH_JR: begin
        next_pc  = {rs_data[31:2], 2'b00};
        misalign = (rs_data[1:0] != 2'b00);
      end
      PATH_BEQ: begin
        if (branch_taken) begin
          next_pc = pc4 + (imm_extended << 2);
        end else begin
          next_pc = pc4;
        end
      end
      default: begin
        next_pc = pc4;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory through a
// valid handshake, pulses the decoder enable and waits for execution to finish.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_ren,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic              dec_en,
  input  logic [3:0]        path_index,
  input  logic [25:0]       jump_address,
  input  logic [31:0]       imm_extended,
  input  logic [31:0]       rs_data,
  input  logic              branch_taken,
  input  logic              exec_done,
  output logic [31:0]       pc,
  output logic [31:0]       link_addr,
  output logic [31:0]       instr_count,
  output logic              halted,
  output logic              misalign_err
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] FETCH  = ST_FETCH;
  localparam logic [2:0] WAIT   = ST_WAIT;
  localparam logic [2:0] DECODE = ST_DECODE;
  localparam logic [2:0] EXEC   = ST_EXEC;
  localparam logic [2:0] HALT   = ST_HALT;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [31:0] next_pc;
  logic        misalign;

  assign imem_addr = pc[ADDR_W+1:2];
  assign link_addr = pc + 32'd4;

  next_pc_logic u_next_pc (
    .pc           (pc),
    .path_index   (path_index),
    .jump_address (jump_address),
    .imm_extended (imm_extended),
    .rs_data      (rs_data),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  // Sequencer next state; inputs outside their owning state are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
        else       state_next = IDLE;
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        if (imem_valid) begin
          if (imem_rdata == HALT_INSTR) state_next = HALT;
          else                          state_next = DECODE;
        end else begin
          state_next = WAIT;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (exec_done) state_next = FETCH;
        else           state_next = EXEC;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State, PC, counters and registered strobes derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= 32'd0;
      instr_count  <= 32'd0;
      imem_ren     <= 1'b0;
      dec_en       <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state    <= state_next;
      imem_ren <= (state_next == FETCH) || (state_next == WAIT);
      dec_en   <= (state_next == DECODE);
      halted   <= (state_next == HALT);
      if ((state == WAIT) && imem_valid) begin
        instr <= imem_rdata;
      end
      if ((state == EXEC) && exec_done) begin
        pc          <= next_pc;
        instr_count <= instr_count + 32'd1;
        if (misalign) misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a table of instructions is stepped through
// the handshake and PC/instruction expectations are queued and compared.
module tb_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] ADDI   = 32'h2008_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_ren;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic        dec_en;
  logic [3:0]  path_index;
  logic [25:0] jump_address;
  logic [31:0] imm_extended;
  logic [31:0] rs_data;
  logic        branch_taken;
  logic        exec_done;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] instr_count;
  logic        halted;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] pc_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_count;
  logic [31:0] prev_instr;

  typedef struct {
    logic [31:0] word;
    int          waits;
    logic [3:0]  path;
    logic [25:0] ja;
    logic [31:0] imm;
    logic [31:0] rs;
    logic        taken;
    int          delay;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } step_t;

  step_t steps[17];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_ren     (imem_ren),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr        (instr),
    .dec_en       (dec_en),
    .path_index   (path_index),
    .jump_address (jump_address),
    .imm_extended (imm_extended),
    .rs_data      (rs_data),
    .branch_taken (branch_taken),
    .exec_done    (exec_done),
    .pc           (pc),
    .link_addr    (link_addr),
    .instr_count  (instr_count),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic step_t mk(input logic [31:0] word, input int waits, input logic [3:0] path,
                               input logic [25:0] ja, input logic [31:0] imm, input logic [31:0] rs,
                               input logic taken, input int delay, input logic [31:0] exp_pc,
                               input logic exp_mis);
    step_t s;
    s.word = word; s.waits = waits; s.path = path; s.ja = ja; s.imm = imm; s.rs = rs;
    s.taken = taken; s.delay = delay; s.exp_pc = exp_pc; s.exp_mis = exp_mis;
    return s;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0000_0000);
    check({tag, "_instr"}, instr, 32'h0000_0000);
    check({tag, "_count"}, instr_count, 32'd0);
    check({tag, "_ren"}, {31'd0, imem_ren}, 32'd0);
    check({tag, "_dec_en"}, {31'd0, dec_en}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
    check({tag, "_link"}, link_addr, 32'h0000_0004);
  endtask

  // Entered in the FETCH cycle; leaves in the next FETCH cycle (or in HALT).
  task automatic run_step(input step_t s, input bit first);
    int ncyc;
    int ren_cycles;
    logic [31:0] exp_word;
    logic [31:0] exp_pc;
    check("fetch_ren", {31'd0, imem_ren}, 32'd1);
    check("fetch_addr", {24'd0, imem_addr}, {24'd0, model_pc[9:2]});
    check("fetch_dec_en", {31'd0, dec_en}, 32'd0);
    ren_cycles = imem_ren ? 1 : 0;
    ncyc = 1;
    tick();
    ncyc++;
    for (int w = 0; w <= s.waits; w++) begin
      check("wait_ren", {31'd0, imem_ren}, 32'd1);
      check("wait_addr", {24'd0, imem_addr}, {24'd0, model_pc[9:2]});
      check("wait_instr_hold", instr, prev_instr);
      if (imem_ren) ren_cycles++;
      if (w < s.waits) begin
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        tick();
        ncyc++;
      end
    end
    imem_valid = 1'b1;
    imem_rdata = s.word;
    instr_q.push_back(s.word);
    tick();
    ncyc++;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    exp_word = instr_q.pop_front();
    check("instr_latch", instr, exp_word);
    check("ren_cycles", ren_cycles, s.waits + 2);
    check("ren_drop", {31'd0, imem_ren}, 32'd0);
    if (s.word == HALT_W) begin
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_no_dec", {31'd0, dec_en}, 32'd0);
      return;
    end
    check("dec_en_pulse", {31'd0, dec_en}, 32'd1);
    if (first) check("dec_latency", ncyc, 3);
    if (s.delay > 0) exec_done = 1'b1;
    tick();
    check("dec_en_single", {31'd0, dec_en}, 32'd0);
    check("link_addr", link_addr, model_pc + 32'd4);
    path_index   = s.path;
    jump_address = (s.path == 4'b0101 || s.path == 4'b0110) ? s.ja : 26'($urandom);
    imm_extended = (s.path == 4'b0100) ? s.imm : $urandom;
    rs_data      = (s.path == 4'b1000) ? s.rs : $urandom;
    branch_taken = (s.path == 4'b0100) ? s.taken : 1'($urandom);
    exec_done    = 1'b0;
    for (int d = 0; d < s.delay; d++) begin
      tick();
      check("exec_pc_hold", pc, model_pc);
    end
    exec_done = 1'b1;
    pc_q.push_back(s.exp_pc);
    tick();
    exec_done = 1'b0;
    path_index = 4'($urandom);
    exp_pc = pc_q.pop_front();
    check("next_pc", pc, exp_pc);
    model_count = model_count + 32'd1;
    check("instr_count", instr_count, model_count);
    check("misalign_err", {31'd0, misalign_err}, {31'd0, s.exp_mis});
    model_pc   = exp_pc;
    prev_instr = s.word;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    steps[0]  = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0004, 1'b0);
    steps[1]  = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0008, 1'b0);
    steps[2]  = mk(ADDI,           3, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 2, 32'h0000_000C, 1'b0);
    steps[3]  = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0010, 1'b0);
    steps[4]  = mk(32'h1000_FFFE,  0, 4'b0100, 26'h0,  32'hFFFF_FFFE, 32'h0,         1'b1, 0, 32'h0000_000C, 1'b0);
    steps[5]  = mk(ADDI,           1, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0010, 1'b0);
    steps[6]  = mk(32'h1000_FFFE,  0, 4'b0100, 26'h0,  32'hFFFF_FFFE, 32'h0,         1'b0, 1, 32'h0000_0014, 1'b0);
    steps[7]  = mk(32'h03E0_0008,  0, 4'b1000, 26'h0,  32'h0,         32'h4000_0000, 1'b0, 0, 32'h4000_0000, 1'b0);
    steps[8]  = mk(32'h0C00_0040,  0, 4'b0110, 26'h40, 32'h0,         32'h0,         1'b0, 0, 32'h4000_0100, 1'b0);
    steps[9]  = mk(32'h0800_0040,  0, 4'b0101, 26'h40, 32'h0,         32'h0,         1'b0, 0, 32'h4000_0100, 1'b0);
    steps[10] = mk(32'h03E0_0008,  0, 4'b1000, 26'h0,  32'h0,         32'h0000_0023, 1'b0, 0, 32'h0000_0020, 1'b1);
    steps[11] = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0024, 1'b1);
    steps[12] = mk(32'h03E0_0008,  0, 4'b1000, 26'h0,  32'h0,         32'hFFFF_FFFC, 1'b0, 0, 32'hFFFF_FFFC, 1'b1);
    steps[13] = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0000, 1'b1);
    steps[14] = mk(ADDI,           0, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0004, 1'b1);
    steps[15] = mk(ADDI,           2, 4'b0001, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0008, 1'b1);
    steps[16] = mk(HALT_W,         0, 4'b0000, 26'h0,  32'h0,         32'h0,         1'b0, 0, 32'h0000_0008, 1'b1);

    rst_n = 1'b0; start = 1'b0; imem_rdata = 32'd0; imem_valid = 1'b0;
    path_index = 4'd0; jump_address = 26'd0; imm_extended = 32'd0; rs_data = 32'd0;
    branch_taken = 1'b0; exec_done = 1'b0;
    model_pc = 32'd0; model_count = 32'd0; prev_instr = 32'd0;
    repeat (2) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check("idle_ren", {31'd0, imem_ren}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) run_step(steps[i], i == 0);

    // HALT is terminal: strobes on every other input are ignored.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; exec_done = 1'b1; imem_valid = 1'b1; imem_rdata = ADDI;
      tick();
      check("halt_ren", {31'd0, imem_ren}, 32'd0);
      check("halt_dec_en", {31'd0, dec_en}, 32'd0);
      check("halt_sticky", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, 32'h0000_0008);
      check("halt_instr", instr, HALT_W);
    end
    start = 1'b0; exec_done = 1'b0; imem_valid = 1'b0;

    rst_n = 1'b0;
    #2;
    check_reset_values("halt_reset");
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_addr", {24'd0, imem_addr}, 32'd0);
    tick();
    check("restart_wait_ren", {31'd0, imem_ren}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("wait_reset");
    imem_valid = 1'b1; imem_rdata = ADDI;
    tick();
    check("reset_drop_read", instr, 32'd0);
    imem_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_pc = 32'd0; model_count = 32'd0; prev_instr = 32'd0;
    run_step(steps[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
